// File: rtl/axi_lite_interface_pkg.sv
// Shared types for the AXI4 register-port front-end: default AXI4 channel
// structs (64-bit address/data, 10-bit ID) and the controller state encoding.
package axi_lite_interface_pkg;

    localparam int unsigned AXI_AW = 64;
    localparam int unsigned AXI_DW = 64;
    localparam int unsigned AXI_IW = 10;
    localparam int unsigned AXI_UW = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [5:0]          atop;
        logic [AXI_UW-1:0]   user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
        logic [AXI_UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [1:0]          resp;
        logic [AXI_UW-1:0]   user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [AXI_UW-1:0]   user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_DW-1:0]   data;
        logic [1:0]          resp;
        logic                last;
        logic [AXI_UW-1:0]   user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_WRITE_B = 2'd3
    } state_e;

endpackage

// File: rtl/axi_lite_interface.sv
// Single-outstanding AXI4 slave that turns one-beat reads/writes into a
// register-port strobe (address, enable, write-enable, write data, read data).
module axi_lite_interface
    import axi_lite_interface_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter type         axi_req_slv_t  = axi_req_t,
    parameter type         axi_rsp_slv_t  = axi_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  axi_req_slv_t              axi_req_i,
    output axi_rsp_slv_t              axi_resp_o,
    output logic [AXI_ADDR_WIDTH-1:0] address_o,
    output logic                      en_o,
    output logic                      we_o,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o
);

    state_e                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_ID_WIDTH-1:0]   r_id;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Read takes priority when AR and AW arrive together.
                    if (axi_req_i.ar_valid) begin
                        r_addr  <= axi_req_i.ar.addr;
                        r_id    <= axi_req_i.ar.id;
                        r_state <= ST_READ;
                    end else if (axi_req_i.aw_valid) begin
                        r_addr  <= axi_req_i.aw.addr;
                        r_id    <= axi_req_i.aw.id;
                        r_state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (axi_req_i.r_ready) r_state <= ST_IDLE;
                end
                ST_WRITE: begin
                    if (axi_req_i.w_valid) r_state <= ST_WRITE_B;
                end
                ST_WRITE_B: begin
                    if (axi_req_i.b_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_resp_o = '0;
        en_o       = 1'b0;
        we_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                axi_resp_o.ar_ready = axi_req_i.ar_valid;
                axi_resp_o.aw_ready = axi_req_i.aw_valid & ~axi_req_i.ar_valid;
            end
            ST_READ: begin
                // Enable stays high while R is back-pressured; register reads
                // must therefore be free of side effects.
                axi_resp_o.r_valid  = 1'b1;
                axi_resp_o.r.data   = data_i;
                axi_resp_o.r.id     = r_id;
                axi_resp_o.r.resp   = RESP_OKAY;
                axi_resp_o.r.last   = 1'b1;
                en_o                = 1'b1;
            end
            ST_WRITE: begin
                axi_resp_o.w_ready  = 1'b1;
                en_o                = axi_req_i.w_valid;
                we_o                = axi_req_i.w_valid;
            end
            ST_WRITE_B: begin
                axi_resp_o.b_valid  = 1'b1;
                axi_resp_o.b.id     = r_id;
                axi_resp_o.b.resp   = RESP_OKAY;
            end
            default: ;
        endcase
    end

    assign address_o = r_addr;
    assign data_o    = axi_req_i.w.data;

endmodule

// File: tb/tb_axi_lite_interface.sv
// Directed + randomized bench: a small register file hangs off the register
// port, and an expected-contents array tracks what completed writes left there.
module tb_axi_lite_interface;
    import axi_lite_interface_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic [63:0] address_o, data_i, data_o;
    logic        en, we;

    int          ncmp  = 0;
    int          nfail = 0;
    int          n_wstrobe = 0;
    logic [63:0] regfile [8];
    logic [63:0] exp_mem [8];

    always #5 clk = ~clk;

    axi_lite_interface dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (rsp),
        .address_o  (address_o),
        .en_o       (en),
        .we_o       (we),
        .data_i     (data_i),
        .data_o     (data_o)
    );

    function automatic logic [63:0] init_val(input int i);
        return (i == 7) ? 64'h1234 : (64'hA5A5_0000_0000_0000 | 64'(i));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regfile[i] <= init_val(i);
        end else if (en && we) begin
            regfile[address_o[5:3]] <= data_o;
            n_wstrobe <= n_wstrobe + 1;
        end
    end

    assign data_i = (en && !we) ? regfile[address_o[5:3]] : 64'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [9:0] id, input int rdelay);
        logic [63:0] exp;
        exp = exp_mem[addr[5:3]];
        req.ar_valid = 1'b1;
        req.ar.addr  = addr;
        req.ar.id    = id;
        settle();
        check("ar_ready", rsp.ar_ready, 1);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b0;
        for (int k = 0; k < rdelay; k++) begin
            settle();
            check("r_valid_hold", rsp.r_valid, 1);
            check("r_en_hold", {en, we}, 2'b10);
            check("r_data_hold", rsp.r.data, exp);
            tick();
        end
        req.r_ready = 1'b1;
        settle();
        check("r_valid", rsp.r_valid, 1);
        check("r_data", rsp.r.data, exp);
        check("r_id", rsp.r.id, id);
        check("r_resp_last", {rsp.r.resp, rsp.r.last}, {RESP_OKAY, 1'b1});
        check("rd_addr", address_o, addr);
        check("ar_ready_busy", rsp.ar_ready, 0);
        tick();
        req.r_ready = 1'b0;
        settle();
        check("r_done", {rsp.r_valid, en}, 2'b00);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [9:0] id, input logic [63:0] data,
                            input int wdelay, input int bdelay, input bit aw_done);
        int s0;
        s0 = n_wstrobe;
        if (!aw_done) begin
            req.aw_valid = 1'b1;
            req.aw.addr  = addr;
            req.aw.id    = id;
            settle();
            check("aw_ready", rsp.aw_ready, 1);
            check("w_ready_idle", rsp.w_ready, 0);
            tick();
        end
        req.aw_valid = 1'b0;
        for (int k = 0; k < wdelay; k++) begin
            settle();
            check("w_wait", {rsp.w_ready, en, rsp.b_valid}, 3'b100);
            tick();
        end
        req.w_valid = 1'b1;
        req.w.data  = data;
        settle();
        check("w_strobe", {rsp.w_ready, en, we}, 3'b111);
        check("w_data", data_o, data);
        check("wr_addr", address_o, addr);
        tick();
        req.w_valid = 1'b0;
        req.b_ready = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            settle();
            check("b_hold", {rsp.b_valid, en, rsp.w_ready}, 3'b100);
            tick();
        end
        req.b_ready = 1'b1;
        settle();
        check("b_valid", rsp.b_valid, 1);
        check("b_id", rsp.b.id, id);
        check("b_resp", rsp.b.resp, RESP_OKAY);
        tick();
        req.b_ready = 1'b0;
        settle();
        check("b_done", {rsp.b_valid, en}, 2'b00);
        check("wstrobe_count", 64'(n_wstrobe - s0), 1);
        exp_mem[addr[5:3]] = data;
    endtask

    initial begin
        logic [63:0] a, d;
        logic [9:0]  id;
        req = '0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) exp_mem[i] = init_val(i);
        tick(); tick();
        settle();
        check("rst_valids", {rsp.r_valid, rsp.b_valid, rsp.w_ready, rsp.ar_ready, rsp.aw_ready}, 5'b0);
        check("rst_en_we", {en, we}, 2'b00);
        check("rst_addr", address_o, 0);
        tick();
        rst = 1'b0;

        do_read(64'hBFF8, 10'd5, 0);
        do_write(64'h4000, 10'd3, 64'hDEAD_BEEF, 0, 0, 1'b0);
        do_read(64'h4000, 10'd3, 0);
        do_read(64'h0010, 10'd1, 5);
        do_write(64'h0018, 10'd2, 64'h0123_4567_89AB_CDEF, 0, 5, 1'b0);
        do_write(64'h0028, 10'd4, 64'hCAFE_F00D, 4, 0, 1'b0);
        do_read(64'h0018, 10'd6, 0);

        // AR and AW in the same cycle: read first, AW held until IDLE again.
        req.ar_valid = 1'b1; req.ar.addr = 64'h0028; req.ar.id = 10'd9;
        req.aw_valid = 1'b1; req.aw.addr = 64'h0030; req.aw.id = 10'h2A;
        settle();
        check("both_ar_ready", rsp.ar_ready, 1);
        check("both_aw_ready", rsp.aw_ready, 0);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        settle();
        check("both_r_data", rsp.r.data, 64'hCAFE_F00D);
        check("both_r_id", rsp.r.id, 9);
        check("both_aw_busy", rsp.aw_ready, 0);
        tick();
        req.r_ready = 1'b0;
        settle();
        check("both_aw_later", rsp.aw_ready, 1);
        tick();
        do_write(64'h0030, 10'h2A, 64'h5555_AAAA, 1, 1, 1'b1);
        do_read(64'h0030, 10'h2A, 2);

        for (int n = 0; n < 60; n++) begin
            a  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            id = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1)
                do_write(a, id, d, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            else
                do_read(a, id, $urandom_range(0, 3));
        end

        // Reset while an R response is being back-pressured.
        req.ar_valid = 1'b1; req.ar.addr = 64'h1238; req.ar.id = 10'd7;
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b0;
        settle();
        check("pre_rst_rvalid", rsp.r_valid, 1);
        rst = 1'b1;
        tick();
        settle();
        check("mid_rst_valids", {rsp.r_valid, rsp.b_valid, rsp.w_ready, en, we}, 5'b0);
        check("mid_rst_addr", address_o, 0);
        rst = 1'b0;
        tick();
        settle();
        check("post_rst_idle", {rsp.r_valid, en}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
